// File: rtl/raw_data_in_fifo.sv
// Show-ahead circular FIFO carrying {data, index, wstrb} with three lane pop inputs and sticky error flags.
// Optional feature: define RAW_DATA_IN_ZERO_STRB_DROP_EN to discard all-zero-strobe entries and count them on drop_count.
module raw_data_in_fifo #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned WSTRB_W = 16,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [INDEX_W-1:0]         wr_index,
    input  logic [WSTRB_W-1:0]         wr_wstrb,
    input  logic                       raw_data_in_fifo_pop,
    input  logic                       raw_data_in_index_pop,
    input  logic                       raw_data_in_wstrb_pop,
    output logic                       raw_data_in_fifo_empty,
    output logic [DATA_W-1:0]          raw_data_in_data,
    output logic [INDEX_W-1:0]         raw_data_in_index,
    output logic [WSTRB_W-1:0]         raw_data_in_wstrb,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_underflow,
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
    output logic                       err_pop_mismatch,
    output logic [15:0]                drop_count
`else
    output logic                       err_pop_mismatch
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + INDEX_W + WSTRB_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_ready_q, wr_ready_d;
    logic             empty_q, empty_d;
    logic             err_uf_q, err_uf_d;
    logic             err_mm_q, err_mm_d;
    logic             push_hs;
    logic             store;
    logic             pop;
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
    logic [15:0]      drop_cnt_q, drop_cnt_d;
`endif

    // Handshake, storage decision and next-state for pointers, occupancy and flags
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        err_uf_d   = err_uf_q;
        err_mm_d   = err_mm_q;
        push_hs    = wr_valid & wr_ready_q;
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
        drop_cnt_d = drop_cnt_q;
        store      = push_hs & (wr_wstrb != '0);
        if (push_hs && (wr_wstrb == '0) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
`else
        store      = push_hs;
`endif
        pop        = raw_data_in_fifo_pop & ~empty_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({store, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        wr_ready_d = (level_d != LVL_W'(DEPTH));
        empty_d    = (level_d == '0);

        if (raw_data_in_fifo_pop && empty_q) begin
            err_uf_d = 1'b1;
        end
        if ((raw_data_in_fifo_pop != raw_data_in_index_pop) ||
            (raw_data_in_fifo_pop != raw_data_in_wstrb_pop)) begin
            err_mm_d = 1'b1;
        end
    end

    // Control state; reset discards everything presented in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
            empty_q    <= 1'b1;
            err_uf_q   <= 1'b0;
            err_mm_q   <= 1'b0;
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
            empty_q    <= empty_d;
            err_uf_q   <= err_uf_d;
            err_mm_q   <= err_mm_d;
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    // Entry storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (store && !reset) begin
            mem_q[wr_ptr_q] <= {wr_data, wr_index, wr_wstrb};
        end
    end

    assign wr_ready               = wr_ready_q;
    assign raw_data_in_fifo_empty = empty_q;
    assign level                  = level_q;
    assign err_underflow          = err_uf_q;
    assign err_pop_mismatch       = err_mm_q;
    assign {raw_data_in_data, raw_data_in_index, raw_data_in_wstrb} = mem_q[rd_ptr_q];
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
    assign drop_count             = drop_cnt_q;
`endif

endmodule

// File: tb/tb_raw_data_in_fifo.sv
// Bench for raw_data_in_fifo: table vectors, directed corner sequences and random traffic against a queue model.
module tb_raw_data_in_fifo;

    localparam int unsigned DW    = 128;
    localparam int unsigned IW    = 8;
    localparam int unsigned SW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic [IW-1:0] wr_index = '0;
    logic [SW-1:0] wr_wstrb = '0;
    logic          fpop = 1'b0, ipop = 1'b0, spop = 1'b0;
    logic          empty;
    logic [DW-1:0] h_data;
    logic [IW-1:0] h_index;
    logic [SW-1:0] h_wstrb;
    logic [LW-1:0] level;
    logic          err_uf, err_mm;
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
    logic [15:0]   drop_count;
`endif

    always #5 clk = ~clk;

    raw_data_in_fifo #(.DATA_W(DW), .INDEX_W(IW), .WSTRB_W(SW), .DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .wr_valid               (wr_valid),
        .wr_ready               (wr_ready),
        .wr_data                (wr_data),
        .wr_index               (wr_index),
        .wr_wstrb               (wr_wstrb),
        .raw_data_in_fifo_pop   (fpop),
        .raw_data_in_index_pop  (ipop),
        .raw_data_in_wstrb_pop  (spop),
        .raw_data_in_fifo_empty (empty),
        .raw_data_in_data       (h_data),
        .raw_data_in_index      (h_index),
        .raw_data_in_wstrb      (h_wstrb),
        .level                  (level),
        .err_underflow          (err_uf),
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
        .err_pop_mismatch       (err_mm),
        .drop_count             (drop_count)
`else
        .err_pop_mismatch       (err_mm)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue, flags as plain bits
    logic [DW+IW+SW-1:0] mq[$];
    logic                m_uf = 1'b0, m_mm = 1'b0;
    int                  m_drop = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic wv, input logic fp, input logic ip, input logic sp,
                        input logic [DW-1:0] d, input logic [IW-1:0] ix, input logic [SW-1:0] ws);
        bit was_full, was_empty, drop;
        reset = rst; wr_valid = wv; fpop = fp; ipop = ip; spop = sp;
        wr_data = d; wr_index = ix; wr_wstrb = ws;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (rst) begin
            mq.delete();
            m_uf = 1'b0; m_mm = 1'b0; m_drop = 0;
        end else begin
            if (fp && was_empty) m_uf = 1'b1;
            if (fp != ip || fp != sp) m_mm = 1'b1;
            if (fp && !was_empty) void'(mq.pop_front());
            drop = 1'b0;
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
            drop = (ws == '0);
`endif
            if (wv && !was_full) begin
                if (drop) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back({d, ix, ws});
                end
            end
        end
        @(posedge clk);
        #1;
        chk("level", DW'(level), DW'(mq.size()));
        chk("empty", DW'(empty), DW'(mq.size() == 0));
        chk("wr_ready", DW'(wr_ready), DW'(mq.size() != DEPTH));
        chk("err_underflow", DW'(err_uf), DW'(m_uf));
        chk("err_pop_mismatch", DW'(err_mm), DW'(m_mm));
        if (mq.size() != 0) begin
            chk("head", DW'({h_data, h_index, h_wstrb} >> (IW + SW)), DW'(mq[0] >> (IW + SW)));
            chk("head_index", DW'(h_index), DW'(mq[0][IW+SW-1:SW]));
            chk("head_wstrb", DW'(h_wstrb), DW'(mq[0][SW-1:0]));
        end
`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
        chk("drop_count", DW'(drop_count), DW'(m_drop));
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    typedef struct {
        logic          rst, wv, pop;
        logic [DW-1:0] d;
        logic [LW-1:0] e_level;
        logic          e_empty, e_ready, e_uf, e_mm;
        logic [DW-1:0] e_head;
    } vec_t;

    vec_t vt[19];

    initial begin
        int n;
        // Table: reset, fill with 0..7, then drain with all pops held for 10 cycles
        vt[0] = '{rst: 1'b1, wv: 1'b0, pop: 1'b0, d: '0, e_level: '0, e_empty: 1'b1,
                  e_ready: 1'b1, e_uf: 1'b0, e_mm: 1'b0, e_head: '0};
        for (int i = 0; i < 8; i++) begin
            vt[1+i] = '{rst: 1'b0, wv: 1'b1, pop: 1'b0, d: DW'(i), e_level: LW'(i + 1), e_empty: 1'b0,
                        e_ready: (i != 7), e_uf: 1'b0, e_mm: 1'b0, e_head: '0};
        end
        for (int k = 0; k < 10; k++) begin
            n = k + 1;
            vt[9+k] = '{rst: 1'b0, wv: 1'b0, pop: 1'b1, d: '0, e_level: LW'((n >= 8) ? 0 : 8 - n),
                        e_empty: (n >= 8), e_ready: 1'b1, e_uf: (n >= 9), e_mm: 1'b0,
                        e_head: DW'(n)};
        end

        for (int v = 0; v < 19; v++) begin
            step(vt[v].rst, vt[v].wv, vt[v].pop, vt[v].pop, vt[v].pop,
                 vt[v].d, IW'(vt[v].d), SW'(16'hFFFF));
            chk("tbl_level", DW'(level), DW'(vt[v].e_level));
            chk("tbl_empty", DW'(empty), DW'(vt[v].e_empty));
            chk("tbl_ready", DW'(wr_ready), DW'(vt[v].e_ready));
            chk("tbl_uf", DW'(err_uf), DW'(vt[v].e_uf));
            chk("tbl_mm", DW'(err_mm), DW'(vt[v].e_mm));
            if (!vt[v].e_empty) chk("tbl_head", h_data, vt[v].e_head);
        end

        // Simultaneous push and pop at level 3 across the pointer wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(100 + i), IW'(i), SW'(16'hFFFF));
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, DW'(103 + k), IW'(k), SW'(16'hFFFF));
            chk("sim_level", DW'(level), DW'(3));
            chk("sim_head", h_data, DW'(101 + k));
        end

        // Full with pop: no push while full, push accepted the following cycle
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(200 + i), IW'(i), SW'(16'h00FF));
        chk("full_level", DW'(level), DW'(8));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, DW'(300), IW'(1), SW'(16'h0F0F));
        chk("fullpop_level", DW'(level), DW'(7));
        chk("fullpop_ready", DW'(wr_ready), DW'(1));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(301), IW'(2), SW'(16'hF0F0));
        chk("fullpop_push", DW'(level), DW'(8));

        // Lane pop mismatch, then reset during a push
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0);
        chk("mismatch_set", DW'(err_mm), DW'(1));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DW'(128'hDEAD), IW'(8'h5A), SW'(16'hFFFF));
        chk("rst_level", DW'(level), DW'(0));
        chk("rst_empty", DW'(empty), DW'(1));
        chk("rst_mm", DW'(err_mm), DW'(0));
        chk("rst_uf", DW'(err_uf), DW'(0));
        idle();
        chk("rst_entry_absent", DW'(empty), DW'(1));

`ifdef RAW_DATA_IN_ZERO_STRB_DROP_EN
        // Zero-strobe entry is accepted but dropped
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(55), IW'(1), SW'(16'h0000));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(66), IW'(2), SW'(16'h000F));
        chk("drop_level", DW'(level), DW'(1));
        chk("drop_cnt", DW'(drop_count), DW'(1));
        chk("drop_head", h_data, DW'(66));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
`endif

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic fp, ip, sp, wv, rst;
            logic [SW-1:0] ws;
            rst = ($urandom_range(0, 63) == 0);
            wv  = ($urandom_range(0, 2) != 0);
            fp  = $urandom_range(0, 1);
            ip  = fp;
            sp  = fp;
            if ($urandom_range(0, 31) == 0) ip = ~fp;
            if ($urandom_range(0, 31) == 0) sp = ~fp;
            ws  = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
            step(rst, wv, fp, ip, sp, {$urandom, $urandom, $urandom, $urandom}, IW'($urandom), ws);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
